// File: rtl/mouse_pos_scheduler.sv
// Frame-synchronous cursor position scheduler: clamps decoder samples, commits them
// at the start of vertical blanking and hides the cursor after a run of idle frames.
module mouse_pos_scheduler #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 600,
  parameter int HIDE_FRAMES = 300
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        pos_valid,
  input  logic        vblnk_in,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        cursor_en,
  output logic        update_tick
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam logic [11:0] X_LIM    = 12'(H_RES);
  localparam logic [11:0] Y_LIM    = 12'(V_RES);
  localparam logic [11:0] X_MAX    = 12'(H_RES - 1);
  localparam logic [11:0] Y_MAX    = 12'(V_RES - 1);
  localparam logic [11:0] X_CENTER = 12'(H_RES / 2);
  localparam logic [11:0] Y_CENTER = 12'(V_RES / 2);
  localparam logic [15:0] HIDE_LIM = 16'(HIDE_FRAMES);
  localparam logic        HIDE_OFF = (HIDE_FRAMES == 0);

  logic [1:0]  state;
  logic        vblnk_d;
  logic        vb_edge;
  logic [11:0] x_clamp;
  logic [11:0] y_clamp;
  logic [11:0] x_hold;
  logic [11:0] y_hold;
  logic        pos_change;
  logic [15:0] idle_cnt;

  assign vb_edge    = vblnk_in & ~vblnk_d;
  assign x_clamp    = (xpos_in >= X_LIM) ? X_MAX : xpos_in;
  assign y_clamp    = (ypos_in >= Y_LIM) ? Y_MAX : ypos_in;
  assign pos_change = (x_hold != xpos_out) || (y_hold != ypos_out);

  // vblnk_d resets high so a blank already in progress at reset release is not an edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d <= 1'b1;
      x_hold  <= X_CENTER;
      y_hold  <= Y_CENTER;
    end else begin
      vblnk_d <= vblnk_in;
      if (pos_valid) begin
        x_hold <= x_clamp;
        y_hold <= y_clamp;
      end
    end
  end

  // COMMIT reads the hold registers before any same-cycle sample overwrites them.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      xpos_out    <= X_CENTER;
      ypos_out    <= Y_CENTER;
      update_tick <= 1'b0;
    end else begin
      update_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (pos_valid) state <= PENDING;
        end
        PENDING: begin
          if (vb_edge) state <= COMMIT;
        end
        COMMIT: begin
          xpos_out    <= x_hold;
          ypos_out    <= y_hold;
          update_tick <= 1'b1;
          state       <= pos_valid ? PENDING : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The counter never exceeds HIDE_LIM, so inequality is the saturation test.
  always_ff @(posedge pclk) begin
    if (rst) begin
      idle_cnt  <= 16'd0;
      cursor_en <= 1'b1;
    end else begin
      if ((state == COMMIT) && pos_change) begin
        idle_cnt <= 16'd0;
      end else if (vb_edge && (idle_cnt != HIDE_LIM)) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      cursor_en <= HIDE_OFF | (idle_cnt != HIDE_LIM);
    end
  end

endmodule

// File: tb/tb_mouse_pos_scheduler.sv
// Directed bench for mouse_pos_scheduler: default, HIDE_FRAMES=3 and HIDE_FRAMES=0
// instances share one stimulus stream.
module tb_mouse_pos_scheduler;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_in = 12'd0;
  logic [11:0] ypos_in = 12'd0;
  logic        pos_valid = 1'b0;
  logic        vblnk_in = 1'b0;

  logic [11:0] x_def, y_def, x_h3, y_h3, x_h0, y_h0;
  logic        en_def, en_h3, en_h0, tick_def, tick_h3, tick_h0;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int tick_base;

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (tick_def === 1'b1) tick_cnt++;

  mouse_pos_scheduler dut_def (
    .pclk(pclk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
    .pos_valid(pos_valid), .vblnk_in(vblnk_in),
    .xpos_out(x_def), .ypos_out(y_def), .cursor_en(en_def), .update_tick(tick_def)
  );

  mouse_pos_scheduler #(.HIDE_FRAMES(3)) dut_h3 (
    .pclk(pclk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
    .pos_valid(pos_valid), .vblnk_in(vblnk_in),
    .xpos_out(x_h3), .ypos_out(y_h3), .cursor_en(en_h3), .update_tick(tick_h3)
  );

  mouse_pos_scheduler #(.HIDE_FRAMES(0)) dut_h0 (
    .pclk(pclk), .rst(rst), .xpos_in(xpos_in), .ypos_in(ypos_in),
    .pos_valid(pos_valid), .vblnk_in(vblnk_in),
    .xpos_out(x_h0), .ypos_out(y_h0), .cursor_en(en_h0), .update_tick(tick_h0)
  );

  task automatic wait_neg(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic strobe(input logic [11:0] x, input logic [11:0] y);
    @(negedge pclk);
    xpos_in   = x;
    ypos_in   = y;
    pos_valid = 1'b1;
    @(negedge pclk);
    pos_valid = 1'b0;
  endtask

  task automatic vblank_frame();
    @(negedge pclk);
    vblnk_in = 1'b1;
    wait_neg(4);
    vblnk_in = 1'b0;
    wait_neg(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_neg(3);
    checks++;
    if (x_def !== 12'd400 || y_def !== 12'd300) begin
      errors++;
      $display("[TB] FAIL reset_pos: got %0d/%0d expected 400/300", x_def, y_def);
    end
    checks++;
    if (tick_def !== 1'b0 || en_def !== 1'b1 || en_h3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_flags: tick=%b en=%b en_h3=%b expected 0/1/1", tick_def, en_def, en_h3);
    end
    rst = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_idle();
    tick_base = tick_cnt;
    for (int i = 0; i < 5; i++) vblank_frame();
    checks++;
    if (tick_cnt - tick_base !== 0) begin
      errors++;
      $display("[TB] FAIL idle_ticks: got %0d expected 0", tick_cnt - tick_base);
    end
    checks++;
    if (x_def !== 12'd400 || y_def !== 12'd300 || en_def !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_state: got %0d/%0d en=%b expected 400/300 en=1", x_def, y_def, en_def);
    end
  endtask

  task automatic test_single_move();
    tick_base = tick_cnt;
    strobe(12'd100, 12'd50);
    wait_neg(3);
    checks++;
    if (x_def !== 12'd400 || y_def !== 12'd300) begin
      errors++;
      $display("[TB] FAIL move_before_blank: got %0d/%0d expected 400/300", x_def, y_def);
    end
    vblnk_in = 1'b1;
    wait_neg(1);
    checks++;
    if (x_def !== 12'd400 || y_def !== 12'd300 || tick_def !== 1'b0) begin
      errors++;
      $display("[TB] FAIL move_edge_plus1: got %0d/%0d tick=%b expected 400/300 tick=0", x_def, y_def, tick_def);
    end
    wait_neg(1);
    checks++;
    if (x_def !== 12'd100 || y_def !== 12'd50 || tick_def !== 1'b1) begin
      errors++;
      $display("[TB] FAIL move_edge_plus2: got %0d/%0d tick=%b expected 100/50 tick=1", x_def, y_def, tick_def);
    end
    wait_neg(2);
    vblnk_in = 1'b0;
    wait_neg(3);
    checks++;
    if (tick_cnt - tick_base !== 1) begin
      errors++;
      $display("[TB] FAIL move_ticks: got %0d expected 1", tick_cnt - tick_base);
    end
  endtask

  task automatic test_clamp_burst();
    tick_base = tick_cnt;
    strobe(12'd10, 12'd10);
    strobe(12'd900, 12'd700);
    strobe(12'd4095, 12'd0);
    vblank_frame();
    checks++;
    if (x_def !== 12'd799 || y_def !== 12'd0 || tick_cnt - tick_base !== 1) begin
      errors++;
      $display("[TB] FAIL burst_commit: got %0d/%0d ticks=%0d expected 799/0 ticks=1", x_def, y_def, tick_cnt - tick_base);
    end
    strobe(12'd799, 12'd599);
    vblank_frame();
    checks++;
    if (x_def !== 12'd799 || y_def !== 12'd599) begin
      errors++;
      $display("[TB] FAIL clamp_edge_pass: got %0d/%0d expected 799/599", x_def, y_def);
    end
    strobe(12'd800, 12'd600);
    vblank_frame();
    checks++;
    if (x_def !== 12'd799 || y_def !== 12'd599) begin
      errors++;
      $display("[TB] FAIL clamp_at_res: got %0d/%0d expected 799/599", x_def, y_def);
    end
  endtask

  task automatic test_vb_collision();
    tick_base = tick_cnt;
    @(negedge pclk);
    xpos_in   = 12'd5;
    ypos_in   = 12'd5;
    pos_valid = 1'b1;
    vblnk_in  = 1'b1;
    @(negedge pclk);
    pos_valid = 1'b0;
    wait_neg(3);
    vblnk_in = 1'b0;
    wait_neg(3);
    checks++;
    if (x_def !== 12'd799 || y_def !== 12'd599 || tick_cnt - tick_base !== 0) begin
      errors++;
      $display("[TB] FAIL vb_collision_same_frame: got %0d/%0d ticks=%0d expected 799/599 ticks=0", x_def, y_def, tick_cnt - tick_base);
    end
    vblank_frame();
    checks++;
    if (x_def !== 12'd5 || y_def !== 12'd5 || tick_cnt - tick_base !== 1) begin
      errors++;
      $display("[TB] FAIL vb_collision_next_frame: got %0d/%0d ticks=%0d expected 5/5 ticks=1", x_def, y_def, tick_cnt - tick_base);
    end
  endtask

  task automatic test_commit_collision();
    tick_base = tick_cnt;
    strobe(12'd3, 12'd3);
    @(negedge pclk);
    vblnk_in = 1'b1;
    @(negedge pclk);
    xpos_in   = 12'd7;
    ypos_in   = 12'd7;
    pos_valid = 1'b1;
    @(negedge pclk);
    pos_valid = 1'b0;
    checks++;
    if (x_def !== 12'd3 || y_def !== 12'd3 || tick_def !== 1'b1) begin
      errors++;
      $display("[TB] FAIL commit_collision_old: got %0d/%0d tick=%b expected 3/3 tick=1", x_def, y_def, tick_def);
    end
    wait_neg(2);
    vblnk_in = 1'b0;
    wait_neg(3);
    vblank_frame();
    checks++;
    if (x_def !== 12'd7 || y_def !== 12'd7 || tick_cnt - tick_base !== 2) begin
      errors++;
      $display("[TB] FAIL commit_collision_new: got %0d/%0d ticks=%0d expected 7/7 ticks=2", x_def, y_def, tick_cnt - tick_base);
    end
  endtask

  task automatic test_hiding();
    strobe(12'd200, 12'd100);
    vblank_frame();
    checks++;
    if (x_h3 !== 12'd200 || y_h3 !== 12'd100 || en_h3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hide_after_move: got %0d/%0d en=%b expected 200/100 en=1", x_h3, y_h3, en_h3);
    end
    vblank_frame();
    vblank_frame();
    checks++;
    if (en_h3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hide_two_frames: got en=%b expected 1", en_h3);
    end
    vblank_frame();
    checks++;
    if (en_h3 !== 1'b0 || en_h0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hide_three_frames: got en_h3=%b en_h0=%b expected 0/1", en_h3, en_h0);
    end
    tick_base = tick_cnt;
    strobe(12'd200, 12'd100);
    vblank_frame();
    checks++;
    if (en_h3 !== 1'b0 || tick_cnt - tick_base !== 1) begin
      errors++;
      $display("[TB] FAIL hide_same_pos: got en=%b ticks=%0d expected 0/1", en_h3, tick_cnt - tick_base);
    end
    strobe(12'd210, 12'd100);
    vblank_frame();
    checks++;
    if (en_h3 !== 1'b1 || en_h0 !== 1'b1 || x_h3 !== 12'd210) begin
      errors++;
      $display("[TB] FAIL hide_new_pos: got en_h3=%b en_h0=%b x=%0d expected 1/1/210", en_h3, en_h0, x_h3);
    end
  endtask

  task automatic test_reset_mid();
    strobe(12'd20, 12'd20);
    @(negedge pclk);
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    checks++;
    if (x_def !== 12'd400 || y_def !== 12'd300 || en_h3 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_now: got %0d/%0d en_h3=%b expected 400/300 en=1", x_def, y_def, en_h3);
    end
    tick_base = tick_cnt;
    vblank_frame();
    checks++;
    if (x_def !== 12'd400 || y_def !== 12'd300 || tick_cnt - tick_base !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_blank: got %0d/%0d ticks=%0d expected 400/300 ticks=0", x_def, y_def, tick_cnt - tick_base);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_move();
    test_clamp_burst();
    test_vb_collision();
    test_commit_collision();
    test_hiding();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
